// File: rtl/masked_hpc1_mul_pipe_if.sv
// masked_hpc1_mul_pipe_if
// Handshake and data bundle for the HPC1 masked multiplier pipeline.
// Directions are named from the multiplier's point of view.
//   in_valid / out_ready / in_rand_valid : upstream handshake and randomness gate
//   in_a, in_b, in_r                    : [lanes][shares] elements (a, b, zero-sharing refresh for b)
//   in_p                                : [lanes][pairs] cross-term randomness
//   out_c / out_valid / in_ready        : shared product and downstream handshake
// Modport slave is the multiplier; master is whatever feeds and drains it.
interface masked_hpc1_mul_pipe_if #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    parameter int NUM_LANES  = 1
);
    localparam int NQ = NUM_SHARES * (NUM_SHARES - 1) / 2;

    logic                                                in_valid;
    logic                                                out_ready;
    logic                                                in_rand_valid;
    logic [NUM_LANES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] in_a;
    logic [NUM_LANES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] in_b;
    logic [NUM_LANES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] in_r;
    logic [NUM_LANES-1:0][NQ-1:0][BIT_WIDTH-1:0]         in_p;
    logic [NUM_LANES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] out_c;
    logic                                                out_valid;
    logic                                                in_ready;

    modport slave (
        input  in_valid, in_rand_valid, in_a, in_b, in_r, in_p, in_ready,
        output out_ready, out_c, out_valid
    );

    modport master (
        output in_valid, in_rand_valid, in_a, in_b, in_r, in_p, in_ready,
        input  out_ready, out_c, out_valid
    );
endinterface

// File: rtl/masked_hpc1_mul_pipe.sv
// masked_hpc1_mul_pipe
// Multi-lane HPC1 masked multiplier with valid/ready flow control.
// Stage 1 registers a and the refreshed b (b ^ r) together with the cross-term
// randomness; stage 2 registers every share product a_i*b_j, re-masked with p
// off the diagonal; the compression XOR is either combinational on the stage-2
// registers (OUT_REG=0, latency 2) or registered once more (OUT_REG=1, latency 3).
// Ports:
//   in_clock : clock, rising edge
//   in_reset : asynchronous active-high reset
//   bus      : masked_hpc1_mul_pipe_if.slave (operands, randomness, handshakes, product)
// Multiplication is in GF(2^W): W=1 AND, W=2 x^2+x+1, W=4 x^4+x+1, W=8 x^8+x^4+x^3+x+1.
module masked_hpc1_mul_pipe #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    parameter int NUM_LANES  = 1,
    parameter int OUT_REG    = 0
) (
    input  logic                         in_clock,
    input  logic                         in_reset,
    masked_hpc1_mul_pipe_if.slave        bus
);
    localparam int N  = NUM_SHARES;
    localparam int W  = BIT_WIDTH;
    localparam int L  = NUM_LANES;
    localparam int NQ = N * (N - 1) / 2;

    localparam int POLY_INT = (W == 8) ? 'h11B :
                              (W == 4) ? 'h13  :
                              (W == 2) ? 'h7   : 'h3;
    localparam logic [W:0] POLY = POLY_INT[W:0];

    typedef logic [L-1:0][N-1:0][W-1:0]         share_vec_t;
    typedef logic [L-1:0][NQ-1:0][W-1:0]        rand_vec_t;
    typedef logic [L-1:0][N-1:0][N-1:0][W-1:0]  cross_vec_t;

    // Carry-less product followed by reduction from the top bit downwards.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        prod = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                prod[i+j] = prod[i+j] ^ (x[j] & y[i]);
            end
        end
        for (int k = 2*W-2; k >= W; k--) begin
            if (prod[k]) begin
                prod[k -: W+1] = prod[k -: W+1] ^ POLY;
            end
        end
        return prod[W-1:0];
    endfunction

    // Index of the unordered pair {i,j}, i != j, in row-major upper-triangle order.
    function automatic int qindex(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * N - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    share_vec_t s1_a;
    share_vec_t s1_b;
    rand_vec_t  s1_p;
    logic       s1_valid;
    cross_vec_t s2_c;
    logic       s2_valid;
    share_vec_t s3_c;
    logic       s3_valid;
    share_vec_t comp;

    logic s1_load;
    logic s2_load;
    logic s3_load;
    logic accept;

    // A stage loads when it is empty or its contents move on this cycle;
    // out_ready depends only on valid flags and in_ready, never on in_valid.
    always_comb begin
        s3_load = !s3_valid || bus.in_ready;
        s2_load = !s2_valid || ((OUT_REG != 0) ? s3_load : bus.in_ready);
        s1_load = !s1_valid || s2_load;
        accept  = bus.in_valid && bus.in_rand_valid && s1_load;
    end

    // a and the refreshed b sit in separate registers so they never meet before a flop.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= bus.in_a;
                s1_b <= bus.in_b ^ bus.in_r;
                s1_p <= bus.in_p;
            end
        end
    end

    // Each pair (i,j) and (j,i) is masked with the same p so it cancels on recombination.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            s2_valid <= 1'b0;
            s2_c     <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int l = 0; l < L; l++) begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            if (i == j) begin
                                s2_c[l][i][j] <= gf_mul(s1_a[l][i], s1_b[l][j]);
                            end else begin
                                s2_c[l][i][j] <= gf_mul(s1_a[l][i], s1_b[l][j]) ^ s1_p[l][qindex(i, j)];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        comp = '0;
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    comp[l][i] = comp[l][i] ^ s2_c[l][i][j];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            always_ff @(posedge in_clock or posedge in_reset) begin
                if (in_reset) begin
                    s3_valid <= 1'b0;
                    s3_c     <= '0;
                end else if (s3_load) begin
                    s3_valid <= s2_valid;
                    if (s2_valid) begin
                        s3_c <= comp;
                    end
                end
            end
        end else begin : g_no_out_reg
            assign s3_valid = 1'b0;
            assign s3_c     = '0;
        end
    endgenerate

    assign bus.out_ready = s1_load;
    assign bus.out_valid = (OUT_REG != 0) ? s3_valid : s2_valid;
    assign bus.out_c     = (OUT_REG != 0) ? s3_c : comp;
endmodule

// File: tb/tb_masked_hpc1_mul_pipe.sv
// tb_masked_hpc1_mul_pipe
// Drives two N=3/W=4/L=4 multipliers (OUT_REG=0 and OUT_REG=1) with shared random
// operands and a small N=2/W=1 instance with a directed vector. Accepted transfers
// push the unmasked GF(16) product into a per-DUT queue; a monitor pops on every
// output handshake and also checks out_ready against pipeline occupancy and hold
// stability under backpressure.
module tb_masked_hpc1_mul_pipe;
    localparam int N  = 3;
    localparam int W  = 4;
    localparam int L  = 4;
    localparam int NQ = N * (N - 1) / 2;

    typedef logic [L-1:0][N-1:0][W-1:0]  shv_t;
    typedef logic [L-1:0][NQ-1:0][W-1:0] pv_t;
    typedef logic [L-1:0][W-1:0]         lv_t;
    typedef struct {
        lv_t prod;
        int  acc_cyc;
    } exp_t;

    logic in_clock = 1'b0;
    logic in_reset = 1'b0;
    always #5 in_clock = ~in_clock;

    masked_hpc1_mul_pipe_if #(.NUM_SHARES(N), .BIT_WIDTH(W), .NUM_LANES(L)) bus0 ();
    masked_hpc1_mul_pipe_if #(.NUM_SHARES(N), .BIT_WIDTH(W), .NUM_LANES(L)) bus1 ();
    masked_hpc1_mul_pipe_if #(.NUM_SHARES(2), .BIT_WIDTH(1), .NUM_LANES(1)) bus_s ();

    masked_hpc1_mul_pipe #(.NUM_SHARES(N), .BIT_WIDTH(W), .NUM_LANES(L), .OUT_REG(0)) u_dut0 (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .bus      (bus0)
    );
    masked_hpc1_mul_pipe #(.NUM_SHARES(N), .BIT_WIDTH(W), .NUM_LANES(L), .OUT_REG(1)) u_dut1 (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .bus      (bus1)
    );
    masked_hpc1_mul_pipe #(.NUM_SHARES(2), .BIT_WIDTH(1), .NUM_LANES(1), .OUT_REG(0)) u_dut_s (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .bus      (bus_s)
    );

    shv_t st_a;
    shv_t st_b;
    shv_t st_r;
    pv_t  st_p;
    logic st_v [2];
    logic st_rv;
    logic st_ready;

    assign bus0.in_a = st_a;  assign bus1.in_a = st_a;
    assign bus0.in_b = st_b;  assign bus1.in_b = st_b;
    assign bus0.in_r = st_r;  assign bus1.in_r = st_r;
    assign bus0.in_p = st_p;  assign bus1.in_p = st_p;
    assign bus0.in_valid = st_v[0];
    assign bus1.in_valid = st_v[1];
    assign bus0.in_rand_valid = st_rv;
    assign bus1.in_rand_valid = st_rv;
    assign bus0.in_ready = st_ready;
    assign bus1.in_ready = st_ready;

    logic rdy [2];
    logic ov  [2];
    shv_t oc  [2];
    assign rdy[0] = bus0.out_ready;  assign rdy[1] = bus1.out_ready;
    assign ov[0]  = bus0.out_valid;  assign ov[1]  = bus1.out_valid;
    assign oc[0]  = bus0.out_c;      assign oc[1]  = bus1.out_c;

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   depth [2] = '{2, 3};
    exp_t sb [2][$];
    int   last_lat [2];
    int   n_out [2] = '{0, 0};
    logic hold_flag [2] = '{1'b0, 1'b0};
    shv_t hold_val [2];
    exp_t mon_e;

    always @(posedge in_clock) cyc <= cyc + 1;

    // GF(2^4) modulo x^4+x+1, Horner form: multiply by x and conditionally add a.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] acc;
        acc = '0;
        for (int i = W-1; i >= 0; i--) begin
            acc = {acc[W-2:0], 1'b0} ^ (acc[W-1] ? 4'h3 : 4'h0);
            if (y[i]) acc = acc ^ x;
        end
        return acc;
    endfunction

    function automatic lv_t unmask(input shv_t c);
        lv_t u;
        u = '0;
        for (int l = 0; l < L; l++)
            for (int s = 0; s < N; s++)
                u[l] = u[l] ^ c[l][s];
        return u;
    endfunction

    function automatic lv_t model_product(input shv_t a, input shv_t b);
        lv_t xa;
        lv_t xb;
        lv_t pr;
        xa = unmask(a);
        xb = unmask(b);
        for (int l = 0; l < L; l++) pr[l] = ref_mul(xa[l], xb[l]);
        return pr;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // r is a sharing of zero per lane so the refresh leaves the unmasked b intact.
    task automatic randomize_txn();
        logic [W-1:0] racc;
        for (int l = 0; l < L; l++) begin
            racc = '0;
            for (int s = 0; s < N; s++) begin
                st_a[l][s] = W'($urandom);
                st_b[l][s] = W'($urandom);
                if (s < N-1) begin
                    st_r[l][s] = W'($urandom);
                    racc = racc ^ st_r[l][s];
                end else begin
                    st_r[l][s] = racc;
                end
            end
            for (int q = 0; q < NQ; q++) st_p[l][q] = W'($urandom);
        end
    endtask

    task automatic apply_stimulus();
        logic a0;
        logic a1;
        randomize_txn();
        st_v[0] = 1'b1;
        st_v[1] = 1'b1;
        for (int k = 0; k < 50 && (st_v[0] || st_v[1]); k++) begin
            @(negedge in_clock);
            a0 = st_v[0] && st_rv && rdy[0];
            a1 = st_v[1] && st_rv && rdy[1];
            @(posedge in_clock);
            #1;
            if (a0) st_v[0] = 1'b0;
            if (a1) st_v[1] = 1'b0;
        end
        if (st_v[0] || st_v[1]) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: got valid still pending, expected accept within 50 cycles");
            st_v[0] = 1'b0;
            st_v[1] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge in_clock);
            if (sb[0].size() == 0 && sb[1].size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d/%0d pending, expected 0/0", sb[0].size(), sb[1].size());
        end
        @(posedge in_clock);
        #1;
    endtask

    always @(negedge in_clock) begin
        if (in_reset) begin
            for (int d = 0; d < 2; d++) begin
                sb[d].delete();
                hold_flag[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                check_output($sformatf("ready_model%0d", d), 64'(rdy[d]),
                             64'((sb[d].size() < depth[d]) || st_ready));
                if (hold_flag[d]) begin
                    check_output($sformatf("hold_valid%0d", d), 64'(ov[d]), 64'd1);
                    check_output($sformatf("hold_data%0d", d), 64'(oc[d]), 64'(hold_val[d]));
                end
                hold_flag[d] = ov[d] && !st_ready;
                hold_val[d]  = oc[d];
                if (ov[d]) begin
                    if (sb[d].size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("[TB] FAIL spurious%0d: got out_valid=1, expected no output pending", d);
                    end else if (st_ready) begin
                        mon_e = sb[d].pop_front();
                        check_output($sformatf("result%0d", d), 64'(unmask(oc[d])), 64'(mon_e.prod));
                        last_lat[d] = cyc - mon_e.acc_cyc;
                        n_out[d]++;
                    end
                end
                if (st_v[d] && st_rv && rdy[d]) begin
                    mon_e.prod    = model_product(st_a, st_b);
                    mon_e.acc_cyc = cyc;
                    sb[d].push_back(mon_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int c0;
        int n0 [2];
        logic found;
        logic done;

        st_a = '0; st_b = '0; st_r = '0; st_p = '0;
        st_v[0] = 1'b0; st_v[1] = 1'b0;
        st_rv = 1'b1; st_ready = 1'b1;
        bus_s.in_valid = 1'b0; bus_s.in_rand_valid = 1'b0; bus_s.in_ready = 1'b1;
        bus_s.in_a = '0; bus_s.in_b = '0; bus_s.in_r = '0; bus_s.in_p = '0;
        #1 in_reset = 1'b1;
        #11;
        for (int d = 0; d < 2; d++) begin
            check_output($sformatf("reset_valid%0d", d), 64'(ov[d]), 64'd0);
            check_output($sformatf("reset_data%0d", d), 64'(oc[d]), 64'd0);
            check_output($sformatf("reset_ready%0d", d), 64'(rdy[d]), 64'd1);
        end
        check_output("reset_valid_s", 64'(bus_s.out_valid), 64'd0);
        check_output("reset_ready_s", 64'(bus_s.out_ready), 64'd1);
        @(negedge in_clock);
        in_reset = 1'b0;
        @(posedge in_clock);
        #1;

        // Directed N=2, W=1 vector: a=(1,0), b=(0,1), r=(1,1), p=1 -> product 1.
        bus_s.in_a[0][0] = 1'b1; bus_s.in_a[0][1] = 1'b0;
        bus_s.in_b[0][0] = 1'b0; bus_s.in_b[0][1] = 1'b1;
        bus_s.in_r[0][0] = 1'b1; bus_s.in_r[0][1] = 1'b1;
        bus_s.in_p[0][0] = 1'b1;
        bus_s.in_valid = 1'b1; bus_s.in_rand_valid = 1'b1;
        @(negedge in_clock);
        check_output("small_ready", 64'(bus_s.out_ready), 64'd1);
        t0 = cyc;
        @(posedge in_clock);
        #1;
        bus_s.in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge in_clock);
            if (bus_s.out_valid) found = 1'b1;
        end
        check_output("small_latency", 64'(cyc - t0), 64'd2);
        check_output("small_result", 64'(^bus_s.out_c), 64'd1);
        @(posedge in_clock);
        #1;

        // Single transfer into an idle pipeline: latency 2 and 3.
        apply_stimulus();
        wait_drain();
        check_output("latency_outreg0", 64'(last_lat[0]), 64'd2);
        check_output("latency_outreg1", 64'(last_lat[1]), 64'd3);

        // 100 back-to-back transfers at full throughput.
        n0[0] = n_out[0]; n0[1] = n_out[1];
        c0 = cyc;
        for (int k = 0; k < 100; k++) apply_stimulus();
        check_output("throughput_cycles", 64'(cyc - c0), 64'd100);
        wait_drain();
        check_output("b2b_count0", 64'(n_out[0] - n0[0]), 64'd100);
        check_output("b2b_count1", 64'(n_out[1] - n0[1]), 64'd100);

        // Backpressure: in_ready low for 5 cycles while 3 transfers are offered.
        n0[0] = n_out[0]; n0[1] = n_out[1];
        st_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) apply_stimulus();
            end
            begin
                repeat (5) @(posedge in_clock);
                #1 st_ready = 1'b1;
            end
        join
        wait_drain();
        check_output("bp_count0", 64'(n_out[0] - n0[0]), 64'd3);
        check_output("bp_count1", 64'(n_out[1] - n0[1]), 64'd3);

        // Randomness not valid for 4 cycles holds off acceptance.
        n0[0] = n_out[0]; n0[1] = n_out[1];
        randomize_txn();
        st_rv = 1'b0;
        st_v[0] = 1'b1; st_v[1] = 1'b1;
        repeat (4) begin
            @(negedge in_clock);
            check_output("rv_stall_valid0", 64'(ov[0]), 64'd0);
            check_output("rv_stall_valid1", 64'(ov[1]), 64'd0);
            @(posedge in_clock);
            #1;
        end
        st_rv = 1'b1;
        @(negedge in_clock);
        @(posedge in_clock);
        #1;
        st_v[0] = 1'b0; st_v[1] = 1'b0;
        wait_drain();
        check_output("rv_count0", 64'(n_out[0] - n0[0]), 64'd1);
        check_output("rv_count1", 64'(n_out[1] - n0[1]), 64'd1);
        check_output("rv_latency0", 64'(last_lat[0]), 64'd2);
        check_output("rv_latency1", 64'(last_lat[1]), 64'd3);

        // Asynchronous reset with two transfers in flight.
        apply_stimulus();
        apply_stimulus();
        @(posedge in_clock);
        #4;
        in_reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_output($sformatf("midreset_valid%0d", d), 64'(ov[d]), 64'd0);
            check_output($sformatf("midreset_data%0d", d), 64'(oc[d]), 64'd0);
            check_output($sformatf("midreset_ready%0d", d), 64'(rdy[d]), 64'd1);
        end
        @(negedge in_clock);
        #2 in_reset = 1'b0;
        @(posedge in_clock);
        #1;
        n0[0] = n_out[0]; n0[1] = n_out[1];
        apply_stimulus();
        wait_drain();
        check_output("post_reset_count0", 64'(n_out[0] - n0[0]), 64'd1);
        check_output("post_reset_count1", 64'(n_out[1] - n0[1]), 64'd1);

        // Random mix of backpressure and randomness gaps.
        n0[0] = n_out[0]; n0[1] = n_out[1];
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) apply_stimulus();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge in_clock);
                    #1;
                    if (!done) begin
                        st_ready = ($urandom_range(0, 3) != 0);
                        st_rv    = ($urandom_range(0, 4) != 0);
                    end
                end
            end
        join
        st_ready = 1'b1;
        st_rv = 1'b1;
        wait_drain();
        check_output("mix_count0", 64'(n_out[0] - n0[0]), 64'd60);
        check_output("mix_count1", 64'(n_out[1] - n0[1]), 64'd60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
